abs_sign_stage: RTL and testbench
=================================

// Module: abs_sign_stage
// PURPOSE
// Elastic two-stage pipeline that splits a two's-complement operand into an unsigned magnitude and a sign flag.
// Sits directly upstream of the sequential unsigned datapath (divider/multiplier core) whose result is sign-restored by NegC.
// The emitted sign flag drives NegC's Neg input after the core finishes.
// The negation uses the same parallel-prefix conditional complementer structure: Z = Neg ? -A : A.
// PARAMETERS
// width  8  operand/magnitude word width in bits (>= 2)
// speed  1  prefix structure of internal negation: 0 serial, 1 Brent-Kung, 2 Sklansky
// PORTS
// clk_i        in   1      clock, all state on rising edge
// rst_ni       in   1      asynchronous active-low reset
// flush_i      in   1      synchronous clear of both pipeline stages
// in_valid_i   in   1      input operand valid
// in_ready_o   out  1      stage can accept operand this cycle
// in_a_i       in   width  operand
// in_signed_i  in   1      1: in_a_i is two's complement; 0: unsigned
// out_valid_o  out  1      magnitude/sign valid
// out_ready_i  in   1      downstream accepts this cycle
// out_mag_o    out  width  |A|, unsigned
// out_neg_o    out  1      1 if operand was negative (signed mode and MSB set)
// BEHAVIOUR
// - Reset (rst_ni=0, async): s1_valid=0, s2_valid=0, all data regs=0; out_valid_o=0, out_mag_o=0, out_neg_o=0.
// - S1 register: {a, signed} captured on input handshake (in_valid_i & in_ready_o).
// - S2 register: {mag, neg} computed from S1 contents and captured when S1 advances.
// - Negate flag: neg = s1_signed & s1_a[width-1]; mag = neg ? (~s1_a + 1) mod 2^width : s1_a.
// - Most-negative input 2^(width-1) gives mag = 2^(width-1), neg=1; this is exact as unsigned, no overflow flag.
// - Zero in signed mode gives mag=0, neg=0. Unsigned mode never negates, whatever the MSB.
// - Advance rules, evaluated in the same cycle:
//   - s2_adv = ~s2_valid | out_ready_i
//   - s1_adv = s1_valid & s2_adv
//   - in_ready_o = ~s1_valid | s2_adv   (combinational from out_ready_i; no register in the ready path)
// - Latency 2 cycles from input handshake to out_valid_o with no backpressure. Throughput 1 operand/cycle.
// - Bubbles collapse: an empty stage always accepts. When both stages are full and out_ready_i=0, in_ready_o=0.
// - Output handshake: out_valid_o & out_ready_i consumes S2. out_mag_o/out_neg_o stay stable while out_valid_o=1 and not consumed.
// - Simultaneous output consume + S1 advance: S2 is reloaded from S1 that cycle; no bubble inserted.
// - Simultaneous S1 advance + input handshake: S1 is reloaded with the new operand.
// - flush_i=1: both valids cleared next edge; an input handshake in that cycle is dropped; flush has priority over all loads.
//   - in_ready_o is unaffected by flush_i.
//   - Data regs may hold stale values after flush; outputs are don't-care while out_valid_o=0.
// - Reset asserted mid-operation: in-flight operands are lost, valids clear immediately (async); no output handshake until refilled.
// - in_a_i/in_signed_i are sampled only on handshake; values outside handshake are ignored.
// TESTING (width=8 unless noted)
// 1. signed 0xFF, 0x80, 0x00, 0x7F back-to-back, out_ready_i=1
//    -> two cycles later, one per cycle: (0x01,1) (0x80,1) (0x00,0) (0x7F,0).
// 2. unsigned 0xFF, 0x80 -> (0xFF,0) (0x80,0); no negation despite MSB set.
// 3. out_ready_i=0, offer 3 operands on consecutive cycles
//    -> first two accepted, in_ready_o=0 on the third.
//    -> raise out_ready_i: outputs emerge in order with no loss or duplication.
// 4. Pipeline full, assert flush_i one cycle with in_valid_i=1
//    -> out_valid_o=0 next cycle; the flushed-cycle operand is never output.
// 5. Drop rst_ni asynchronously between edges with both stages full
//    -> out_valid_o=0 immediately; after release, signed 0x81 -> (0x7F,1) at latency 2.
// 6. Random signed/unsigned stream with random out_ready_i, width in {8,13,32}, speed in {0,1,2}
//    -> scoreboard matches behavioural abs/sign model in order.

Source files
------------

// File: rtl/abs_sign_stage.sv
// Two-stage elastic pipeline: splits an operand into an unsigned magnitude and a sign flag.
// Latency 2 cycles from input handshake to out_valid_o; throughput 1 operand per cycle.
// Backpressure: in_ready_o = ~s1_valid | s2_adv, combinational from out_ready_i; an empty stage always accepts.
module abs_sign_stage #(
    parameter int width = 8,
    parameter int speed = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] in_a_i,
    input  logic             in_signed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [width-1:0] out_mag_o,
    output logic             out_neg_o
);

    localparam int NL = $clog2(width);

    logic             s1_vld_q, s1_vld_d;
    logic             s1_sgn_q, s1_sgn_d;
    logic [width-1:0] s1_a_q, s1_a_d;
    logic             s2_vld_q, s2_vld_d;
    logic             s2_neg_q, s2_neg_d;
    logic [width-1:0] s2_mag_q, s2_mag_d;

    logic             s2_adv, s1_adv, in_hs;
    logic             neg;
    logic [width-1:0] pre;
    logic [width-1:0] mag;

    assign s2_adv     = ~s2_vld_q | out_ready_i;
    assign s1_adv     = s1_vld_q & s2_adv;
    assign in_ready_o = ~s1_vld_q | s2_adv;
    assign in_hs      = in_valid_i & in_ready_o;

    // pre[i] = OR of s1_a_q[i:0]; conditional negate flips every bit above the lowest set bit.
    generate
        if (speed == 0) begin : g_serial
            for (genvar i = 0; i < width; i++) begin : g_ser
                logic b;
                if (i == 0) begin : g_first
                    assign b = s1_a_q[0];
                end else begin : g_rest
                    assign b = g_ser[i-1].b | s1_a_q[i];
                end
                assign pre[i] = b;
            end
        end else if (speed == 2) begin : g_sklansky
            for (genvar l = 0; l < NL; l++) begin : g_skl
                logic [width-1:0] src;
                logic [width-1:0] v;
                if (l == 0) begin : g_src0
                    assign src = s1_a_q;
                end else begin : g_srcn
                    assign src = g_skl[l-1].v;
                end
                for (genvar i = 0; i < width; i++) begin : g_bit
                    if (((i >> l) & 1) == 1) begin : g_op
                        assign v[i] = src[i] | src[((i >> l) << l) - 1];
                    end else begin : g_pass
                        assign v[i] = src[i];
                    end
                end
            end
            assign pre = g_skl[NL-1].v;
        end else begin : g_brent_kung
            for (genvar l = 0; l < NL; l++) begin : g_up
                logic [width-1:0] src;
                logic [width-1:0] v;
                if (l == 0) begin : g_src0
                    assign src = s1_a_q;
                end else begin : g_srcn
                    assign src = g_up[l-1].v;
                end
                for (genvar i = 0; i < width; i++) begin : g_bit
                    if (((i + 1) % (2 << l)) == 0) begin : g_op
                        assign v[i] = src[i] | src[i - (1 << l)];
                    end else begin : g_pass
                        assign v[i] = src[i];
                    end
                end
            end
            for (genvar k = 0; k < NL - 1; k++) begin : g_dn
                localparam int S = 1 << (NL - 2 - k);
                logic [width-1:0] src;
                logic [width-1:0] v;
                if (k == 0) begin : g_src0
                    assign src = g_up[NL-1].v;
                end else begin : g_srcn
                    assign src = g_dn[k-1].v;
                end
                for (genvar i = 0; i < width; i++) begin : g_bit
                    if ((i >= 3 * S - 1) && (((i - (3 * S - 1)) % (2 * S)) == 0)) begin : g_op
                        assign v[i] = src[i] | src[i - S];
                    end else begin : g_pass
                        assign v[i] = src[i];
                    end
                end
            end
            if (NL > 1) begin : g_out_dn
                assign pre = g_dn[NL-2].v;
            end else begin : g_out_up
                assign pre = g_up[NL-1].v;
            end
        end
    endgenerate

    assign neg = s1_sgn_q & s1_a_q[width-1];
    assign mag = s1_a_q ^ ({pre[width-2:0], 1'b0} & {width{neg}});

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_sgn_d = s1_sgn_q;
        s1_a_d   = s1_a_q;
        s2_vld_d = s2_vld_q;
        s2_neg_d = s2_neg_q;
        s2_mag_d = s2_mag_q;
        if (in_hs) begin
            s1_a_d   = in_a_i;
            s1_sgn_d = in_signed_i;
        end
        if (s1_adv) begin
            s2_mag_d = mag;
            s2_neg_d = neg;
        end
        if (flush_i) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end else begin
            s1_vld_d = in_hs | (s1_vld_q & ~s1_adv);
            s2_vld_d = s1_adv | (s2_vld_q & ~out_ready_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q <= 1'b0;
            s1_sgn_q <= 1'b0;
            s1_a_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_neg_q <= 1'b0;
            s2_mag_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_sgn_q <= s1_sgn_d;
            s1_a_q   <= s1_a_d;
            s2_vld_q <= s2_vld_d;
            s2_neg_q <= s2_neg_d;
            s2_mag_q <= s2_mag_d;
        end
    end

    assign out_valid_o = s2_vld_q;
    assign out_mag_o   = s2_mag_q;
    assign out_neg_o   = s2_neg_q;

endmodule

// File: tb/tb_abs_sign_stage.sv
// Bench for abs_sign_stage: directed scenarios plus a random stream on three width/speed variants.
module tb_abs_sign_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_vld;
    logic        in_sgn;
    logic        out_rdy;
    logic [31:0] in_r;

    logic        rdy8, vld8, neg8;
    logic [7:0]  mag8;
    logic        rdy13, vld13, neg13;
    logic [12:0] mag13;
    logic        rdy32, vld32, neg32;
    logic [31:0] mag32;

    logic [32:0] q8[$];
    logic [32:0] q13[$];
    logic [32:0] q32[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    abs_sign_stage #(.width(8), .speed(1)) u8 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_vld), .in_ready_o(rdy8), .in_a_i(in_r[7:0]), .in_signed_i(in_sgn),
        .out_valid_o(vld8), .out_ready_i(out_rdy), .out_mag_o(mag8), .out_neg_o(neg8)
    );

    abs_sign_stage #(.width(13), .speed(0)) u13 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_vld), .in_ready_o(rdy13), .in_a_i(in_r[12:0]), .in_signed_i(in_sgn),
        .out_valid_o(vld13), .out_ready_i(out_rdy), .out_mag_o(mag13), .out_neg_o(neg13)
    );

    abs_sign_stage #(.width(32), .speed(2)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_vld), .in_ready_o(rdy32), .in_a_i(in_r), .in_signed_i(in_sgn),
        .out_valid_o(vld32), .out_ready_i(out_rdy), .out_mag_o(mag32), .out_neg_o(neg32)
    );

    // Behavioural abs/sign: returns {neg, 32-bit zero-extended magnitude}.
    function automatic logic [32:0] model(input logic [31:0] a, input logic s, input int w);
        logic [31:0] mask;
        logic [31:0] am;
        logic        n;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am   = a & mask;
        n    = s & am[w-1];
        return {n, n ? ((~am + 32'd1) & mask) : am};
    endfunction

    task automatic drive(input logic v, input logic s, input logic [31:0] a, input logic r);
        in_vld  = v;
        in_sgn  = s;
        in_r    = a;
        out_rdy = r;
    endtask

    // One cycle: settle, consume/record handshakes on every instance, advance to next negedge.
    task automatic tick();
        logic [32:0] exp;
        logic [32:0] act;
        #1;
        if (vld8 && out_rdy) begin
            total++;
            act = {neg8, 24'd0, mag8};
            if (q8.size() == 0) begin
                bad++;
                $display("FAIL sb8_unexpected got=%h want=none", act);
            end else begin
                exp = q8.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("FAIL sb8 got=%h want=%h", act, exp);
                end
            end
        end
        if (vld13 && out_rdy) begin
            total++;
            act = {neg13, 19'd0, mag13};
            if (q13.size() == 0) begin
                bad++;
                $display("FAIL sb13_unexpected got=%h want=none", act);
            end else begin
                exp = q13.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("FAIL sb13 got=%h want=%h", act, exp);
                end
            end
        end
        if (vld32 && out_rdy) begin
            total++;
            act = {neg32, mag32};
            if (q32.size() == 0) begin
                bad++;
                $display("FAIL sb32_unexpected got=%h want=none", act);
            end else begin
                exp = q32.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("FAIL sb32 got=%h want=%h", act, exp);
                end
            end
        end
        if (flush) begin
            q8.delete();
            q13.delete();
            q32.delete();
        end else begin
            if (in_vld && rdy8)  q8.push_back(model(in_r, in_sgn, 8));
            if (in_vld && rdy13) q13.push_back(model(in_r, in_sgn, 13));
            if (in_vld && rdy32) q32.push_back(model(in_r, in_sgn, 32));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({vld8, neg8, mag8} !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", {vld8, neg8, mag8}, 10'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (rdy8 !== 1'b1 || vld8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got=rdy%b/vld%b want=rdy1/vld0", rdy8, vld8);
        end
        @(negedge clk);
    endtask

    task automatic test_signed_b2b();
        drive(1, 1, 32'hFF, 1);
        #1;
        total++;
        if (vld8 !== 1'b0) begin bad++; $display("FAIL t1_lat0 got=%b want=0", vld8); end
        tick();
        drive(1, 1, 32'h80, 1);
        #1;
        total++;
        if (vld8 !== 1'b0) begin bad++; $display("FAIL t1_lat1 got=%b want=0", vld8); end
        tick();
        drive(1, 1, 32'h00, 1);
        #1;
        total++;
        if ({vld8, neg8, mag8} !== {1'b1, 1'b1, 8'h01}) begin
            bad++;
            $display("FAIL t1_lat2 got=%h want=%h", {vld8, neg8, mag8}, {1'b1, 1'b1, 8'h01});
        end
        tick();
        drive(1, 1, 32'h7F, 1);
        tick();
        drive(0, 0, 0, 1);
        repeat (3) tick();
        total++;
        if (q8.size() !== 0) begin bad++; $display("FAIL t1_drain got=%0d want=0", q8.size()); end
    endtask

    task automatic test_unsigned();
        drive(1, 0, 32'hFF, 1);
        tick();
        drive(1, 0, 32'h80, 1);
        tick();
        drive(0, 0, 0, 1);
        #1;
        total++;
        if ({vld8, neg8, mag8} !== {1'b1, 1'b0, 8'hFF}) begin
            bad++;
            $display("FAIL t2_ff got=%h want=%h", {vld8, neg8, mag8}, {1'b1, 1'b0, 8'hFF});
        end
        tick();
        #1;
        total++;
        if ({vld8, neg8, mag8} !== {1'b1, 1'b0, 8'h80}) begin
            bad++;
            $display("FAIL t2_80 got=%h want=%h", {vld8, neg8, mag8}, {1'b1, 1'b0, 8'h80});
        end
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        drive(1, 1, 32'h85, 0);
        #1;
        total++;
        if (rdy8 !== 1'b1) begin bad++; $display("FAIL t3_rdy0 got=%b want=1", rdy8); end
        tick();
        drive(1, 0, 32'h33, 0);
        #1;
        total++;
        if (rdy8 !== 1'b1) begin bad++; $display("FAIL t3_rdy1 got=%b want=1", rdy8); end
        tick();
        drive(1, 1, 32'hC0, 0);
        repeat (2) begin
            #1;
            total++;
            if ({rdy8, vld8, neg8, mag8} !== {1'b0, 1'b1, 1'b1, 8'h7B}) begin
                bad++;
                $display("FAIL t3_full got=%h want=%h", {rdy8, vld8, neg8, mag8},
                         {1'b0, 1'b1, 1'b1, 8'h7B});
            end
            tick();
        end
        drive(1, 1, 32'hC0, 1);
        #1;
        total++;
        if (rdy8 !== 1'b1) begin bad++; $display("FAIL t3_release got=%b want=1", rdy8); end
        tick();
        drive(0, 0, 0, 1);
        repeat (4) tick();
        total++;
        if (q8.size() !== 0) begin bad++; $display("FAIL t3_drain got=%0d want=0", q8.size()); end
    endtask

    task automatic test_flush();
        drive(1, 1, 32'h90, 0);
        tick();
        drive(1, 1, 32'h91, 0);
        tick();
        flush = 1'b1;
        drive(1, 1, 32'hAA, 1);
        #1;
        total++;
        if (rdy8 !== 1'b1) begin bad++; $display("FAIL t4_rdy_flush got=%b want=1", rdy8); end
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (vld8 !== 1'b0) begin bad++; $display("FAIL t4_flushed got=%b want=0", vld8); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1, 1, 32'h10, 0);
        tick();
        drive(1, 1, 32'h20, 0);
        tick();
        drive(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({vld8, vld13, vld32} !== 3'b000) begin
            bad++;
            $display("FAIL t5_async got=%b want=000", {vld8, vld13, vld32});
        end
        q8.delete();
        q13.delete();
        q32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 32'h81, 1);
        #1;
        total++;
        if (vld8 !== 1'b0) begin bad++; $display("FAIL t5_lat0 got=%b want=0", vld8); end
        tick();
        drive(0, 0, 0, 1);
        tick();
        #1;
        total++;
        if ({vld8, neg8, mag8} !== {1'b1, 1'b1, 8'h7F}) begin
            bad++;
            $display("FAIL t5_refill got=%h want=%h", {vld8, neg8, mag8}, {1'b1, 1'b1, 8'h7F});
        end
        repeat (2) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom(),
                  $urandom_range(0, 9) < 6);
            tick();
        end
        drive(0, 0, 0, 1);
        repeat (4) tick();
        total++;
        if (q8.size() + q13.size() + q32.size() !== 0) begin
            bad++;
            $display("FAIL rand_drain got=%0d/%0d/%0d want=0/0/0", q8.size(), q13.size(), q32.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_signed_b2b();
        test_unsigned();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
